// File: rtl/mux_nx1_arb_pkg.sv
// Shared definitions for the N:1 registered bus multiplexer / arbiter:
// mode encodings, default geometry and a select range helper.
package mux_nx1_arb_pkg;

   // mode input encodings
   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   // default geometry
   localparam int DEF_WIDTH = 16;
   localparam int DEF_N     = 4;
   localparam int DEF_SELW  = 2;

   // true when an address-mode select names an existing channel
   function automatic logic sel_in_range(input int sel, input int n);
      return (sel < n);
   endfunction

endpackage

// File: rtl/mux_nx1_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
// With lock set and the previous winner (ptr) still requesting, that winner
// keeps the grant so a source can stream a back-to-back burst.
module rr_arbiter
   import mux_nx1_arb_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int SELW = DEF_SELW
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  logic            lock,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] gnt_idx
);

   logic found_s;
   logic hit_s;
   int   cand_s;

   // rotating priority search starting just after the last winner
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      cand_s  = 0;
      if (lock && req[ptr]) begin
         gnt[ptr] = 1'b1;
         gnt_idx  = ptr;
      end else begin
         for (int k = 1; k <= N; k++) begin
            cand_s       = (int'(ptr) + k) % N;
            hit_s        = !found_s && req[cand_s];
            gnt[cand_s]  = gnt[cand_s] | hit_s;
            gnt_idx      = hit_s ? SELW'(cand_s) : gnt_idx;
            found_s      = found_s | hit_s;
         end
      end
   end

endmodule

// File: rtl/mux_nx1_arb.sv
// N-input, WIDTH-bit registered bus multiplexer with valid/ready handshake.
// mode 0 selects the channel addressed by sel; mode 1 arbitrates round-robin
// among valid channels. Optional macro MUXARB_LOCK_EN adds a lock input that
// lets the last round-robin winner keep the grant while it stays valid.
module mux_nx1_arb
   import mux_nx1_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N,
   parameter int SELW  = DEF_SELW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
`ifdef MUXARB_LOCK_EN
   input  logic               lock,
`endif
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_chan,
   input  logic               out_ready,
   output logic               sel_err
);

   logic               lock_s;
   logic [N-1:0]       rr_gnt_s;
   logic [SELW-1:0]    rr_idx_s;
   logic [N-1:0]       addr_gnt_s;
   logic [N-1:0]       grant_s;
   logic [SELW-1:0]    gidx_s;
   logic               can_load_s;
   logic               sel_ok_s;
   logic               accept_s;
   logic [N-1:0]       in_ready_s;

   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q,  out_data_d;
   logic [SELW-1:0]    out_chan_q,  out_chan_d;
   logic               sel_err_q,   sel_err_d;
   logic [SELW-1:0]    ptr_q,       ptr_d;

`ifdef MUXARB_LOCK_EN
   assign lock_s = lock;
`else
   assign lock_s = 1'b0;
`endif

   rr_arbiter #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req     (in_valid),
      .ptr     (ptr_q),
      .lock    (lock_s),
      .gnt     (rr_gnt_s),
      .gnt_idx (rr_idx_s)
   );

   // grant selection by mode and the resulting per-channel accept strobes
   always_comb begin
      can_load_s = !out_valid_q || out_ready;
      sel_ok_s   = sel_in_range(int'(sel), N);
      addr_gnt_s = '0;
      if (sel_ok_s) begin
         addr_gnt_s[sel] = in_valid[sel];
      end else begin
         addr_gnt_s = '0;
      end
      if (mode == MODE_RR) begin
         grant_s = rr_gnt_s;
         gidx_s  = rr_idx_s;
      end else begin
         grant_s = addr_gnt_s;
         gidx_s  = sel;
      end
      if (can_load_s) begin
         in_ready_s = grant_s;
      end else begin
         in_ready_s = '0;
      end
      accept_s = |(in_ready_s & in_valid);
   end

   // next state of the output stage, pointer and select-error flag
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      sel_err_d   = can_load_s && (mode == MODE_ADDR) && !sel_ok_s;
      if (can_load_s) begin
         if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(gidx_s)*WIDTH +: WIDTH];
            out_chan_d  = gidx_s;
            if (mode == MODE_RR) begin
               ptr_d = gidx_s;
            end else begin
               ptr_d = ptr_q;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // state registers; pointer resets to N-1 so channel 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         sel_err_q   <= 1'b0;
         ptr_q       <= SELW'(N - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         sel_err_q   <= sel_err_d;
         ptr_q       <= ptr_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign sel_err   = sel_err_q;

endmodule
